// File: rtl/board_ctrl_if.sv
// Key handshake and mergeBoard bus shared by the game controller and its environment.
// The master side is the controller; the slave side is the key source plus mergeBoard.
interface board_ctrl_if;
   logic        key_valid;
   logic [1:0]  key_dir;
   logic        key_ready;
   logic [79:0] mb_board;
   logic [1:0]  mb_dir;
   logic        mb_movable;
   logic [79:0] mb_board_after;

   modport master (
      input  key_valid, key_dir, mb_movable, mb_board_after,
      output key_ready, mb_board, mb_dir
   );

   modport slave (
      output key_valid, key_dir, mb_movable, mb_board_after,
      input  key_ready, mb_board, mb_dir
   );
endinterface

// File: rtl/board_ctrl.sv
// Game sequencer around the combinational mergeBoard engine: owns the board register,
// accepts direction keys, spawns random tiles and probes all directions for game over.
module board_ctrl #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned WIN_EXP   = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         load,
   input  logic [79:0]  load_board,
   board_ctrl_if.master bus,
   output logic [79:0]  board,
   output logic         game_over,
   output logic         win
);
   typedef enum logic [2:0] {IDLE, SPAWN, CHECK, WAIT_KEY, MOVE, COMMIT, OVER} state_t;

   localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [4:0]  WIN_CELL = 5'(WIN_EXP);

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [3:0]  spawn_idx;
   logic [4:0]  spawn_val;
   logic [1:0]  spawn_cnt;
   logic [3:0]  probe_cnt;
   logic [1:0]  chk_dir;
   logic        chk_phase;
   logic [1:0]  dir_q;
   logic [4:0]  cells [16];
   logic        cell_empty, load_ok, spawn_enter, check_enter;
   logic        board_we, key_ready;
   logic [79:0] board_nxt;
   logic [4:0]  fresh_val;

   function automatic logic has_win(input logic [79:0] b);
      has_win = 1'b0;
      for (int i = 0; i < 16; i++)
         if (b[5*i +: 5] >= WIN_CELL) has_win = 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < 16; i++) cells[i] = board[5*i +: 5];
   end

   assign cell_empty     = (cells[spawn_idx] == 5'd0);
   assign fresh_val      = (lfsr[7:4] == 4'd0) ? 5'd2 : 5'd1;
   assign load_ok        = load && (state == IDLE || state == WAIT_KEY || state == OVER);
   assign spawn_enter    = start || (state == COMMIT && bus.mb_movable);
   assign check_enter    = (state_nxt == CHECK) && (state != CHECK);
   assign bus.mb_board   = board;
   assign bus.mb_dir     = dir_q;
   assign bus.key_ready  = key_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) state_nxt = SPAWN;
      else begin
         case (state)
            IDLE:     if (load_ok) state_nxt = CHECK;
            SPAWN:    if (cell_empty ? (spawn_cnt == 2'd1) : (probe_cnt == 4'd15)) state_nxt = CHECK;
            CHECK:    if (chk_phase) begin
                         if (bus.mb_movable)      state_nxt = WAIT_KEY;
                         else if (chk_dir == 2'd3) state_nxt = OVER;
                      end
            WAIT_KEY: if (load_ok) state_nxt = CHECK;
                      else if (bus.key_valid) state_nxt = MOVE;
            MOVE:     state_nxt = COMMIT;
            COMMIT:   state_nxt = bus.mb_movable ? SPAWN : WAIT_KEY;
            OVER:     if (load_ok) state_nxt = CHECK;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // A spawn write only touches the cell currently under the scan index.
   always_comb begin
      key_ready = (state == WAIT_KEY);
      board_we  = 1'b0;
      board_nxt = board;
      if (start) begin
         board_we  = 1'b1;
         board_nxt = '0;
      end else if (load_ok) begin
         board_we  = 1'b1;
         board_nxt = load_board;
      end else if (state == COMMIT && bus.mb_movable) begin
         board_we  = 1'b1;
         board_nxt = bus.mb_board_after;
      end else if (state == SPAWN && cell_empty) begin
         board_we  = 1'b1;
         for (int i = 0; i < 16; i++)
            if (4'(i) == spawn_idx) board_nxt[5*i +: 5] = spawn_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr  <= SEED;
         board <= '0;
         win   <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (board_we) board <= board_nxt;
         if (start)                             win <= 1'b0;
         else if (board_we && has_win(board_nxt)) win <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spawn_idx <= '0;
         spawn_val <= '0;
         spawn_cnt <= '0;
         probe_cnt <= '0;
         chk_dir   <= '0;
         chk_phase <= 1'b0;
         dir_q     <= '0;
         game_over <= 1'b0;
      end else begin
         if (spawn_enter) begin
            spawn_cnt <= start ? 2'd2 : 2'd1;
            spawn_idx <= lfsr[3:0];
            spawn_val <= fresh_val;
            probe_cnt <= '0;
         end else if (state == SPAWN) begin
            if (cell_empty) begin
               spawn_cnt <= spawn_cnt - 2'd1;
               spawn_idx <= lfsr[3:0];
               spawn_val <= fresh_val;
               probe_cnt <= '0;
            end else begin
               spawn_idx <= spawn_idx + 4'd1;
               probe_cnt <= probe_cnt + 4'd1;
            end
         end

         // Each probe takes two cycles: drive the direction, then sample movable.
         if (check_enter) begin
            chk_dir   <= '0;
            chk_phase <= 1'b0;
         end else if (state == CHECK) begin
            chk_phase <= !chk_phase;
            if (chk_phase && !bus.mb_movable) chk_dir <= chk_dir + 2'd1;
         end

         if (!start) begin
            if (state == WAIT_KEY && !load_ok && bus.key_valid) dir_q <= bus.key_dir;
            else if (state == CHECK && !chk_phase)              dir_q <= chk_dir;
         end

         if (start || load_ok)
            game_over <= 1'b0;
         else if (state == CHECK && chk_phase && !bus.mb_movable && chk_dir == 2'd3)
            game_over <= 1'b1;
      end
   end
endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: models mergeBoard, the spawn LFSR and the game
// rules at board level and compares after every directed or random step.
module tb_board_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        load;
   logic [79:0] load_board;
   logic [79:0] board;
   logic        game_over;
   logic        win;

   int          checks = 0;
   int          errors = 0;
   logic [79:0] board_m;
   logic        win_m;
   logic [15:0] lfsr_m;
   int          last_cyc;

   board_ctrl_if bus ();

   board_ctrl #(.LFSR_SEED(16'hACE1), .WIN_EXP(11)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load       (load),
      .load_board (load_board),
      .bus        (bus.master),
      .board      (board),
      .game_over  (game_over),
      .win        (win)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   function automatic logic [15:0] adv(input logic [15:0] x, input int t);
      logic [15:0] y = x;
      for (int i = 0; i < t; i++) y = step(y);
      return y;
   endfunction

   // Dir 0 slides toward lower index within a row, 1 toward higher, 2 up columns, 3 down.
   function automatic logic [79:0] merge(input logic [79:0] b, input logic [1:0] dir);
      logic [79:0] r;
      int pos [4];
      int vals [4];
      logic [4:0] outv [4];
      int nv, no, k;
      r = b;
      for (int line = 0; line < 4; line++) begin
         for (int j = 0; j < 4; j++)
            case (dir)
               2'd0:    pos[j] = 4*line + j;
               2'd1:    pos[j] = 4*line + 3 - j;
               2'd2:    pos[j] = line + 4*j;
               default: pos[j] = line + 4*(3 - j);
            endcase
         nv = 0;
         for (int j = 0; j < 4; j++)
            if (b[5*pos[j] +: 5] != 5'd0) begin
               vals[nv] = int'(b[5*pos[j] +: 5]);
               nv++;
            end
         for (int j = 0; j < 4; j++) outv[j] = 5'd0;
         no = 0;
         k  = 0;
         while (k < nv) begin
            if (k + 1 < nv && vals[k] == vals[k+1]) begin
               outv[no] = 5'(vals[k] + 1);
               k += 2;
            end else begin
               outv[no] = 5'(vals[k]);
               k++;
            end
            no++;
         end
         for (int j = 0; j < 4; j++) r[5*pos[j] +: 5] = outv[j];
      end
      return r;
   endfunction

   function automatic int first_movable(input logic [79:0] b);
      for (int d = 0; d < 4; d++)
         if (merge(b, 2'(d)) != b) return d;
      return -1;
   endfunction

   function automatic logic any_win(input logic [79:0] b);
      for (int i = 0; i < 16; i++)
         if (b[5*i +: 5] >= 5'd11) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int count_nz(input logic [79:0] b);
      int n = 0;
      for (int i = 0; i < 16; i++)
         if (b[5*i +: 5] != 5'd0) n++;
      return n;
   endfunction

   // l0 is the LFSR value at the entry edge; t counts cycles spent inside the spawn.
   function automatic logic [79:0] predict_spawn(input logic [79:0] b0, input logic [15:0] l0, input int n);
      logic [79:0] b = b0;
      logic [15:0] s = l0;
      logic [4:0]  v;
      int t = 0;
      int pos, probes;
      bit placed;
      for (int tile = 0; tile < n; tile++) begin
         pos    = int'(s[3:0]);
         v      = (s[7:4] == 4'd0) ? 5'd2 : 5'd1;
         probes = 0;
         placed = 0;
         while (!placed && probes < 16) begin
            t++;
            if (b[5*pos +: 5] == 5'd0) begin
               b[5*pos +: 5] = v;
               placed = 1;
               s = adv(l0, t);
            end else begin
               pos = (pos + 1) % 16;
               probes++;
            end
         end
         if (!placed) break;
      end
      return b;
   endfunction

   always_comb begin
      bus.mb_board_after = merge(bus.mb_board, bus.mb_dir);
      bus.mb_movable     = (bus.mb_board_after != bus.mb_board);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 16'hACE1;
      else        lfsr_m <= step(lfsr_m);
   end

   task automatic check_output(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_settled();
      int cyc = 0;
      int fm;
      while (!(bus.key_ready || game_over) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      last_cyc = cyc;
      fm = first_movable(board_m);
      check_output("board", board, board_m);
      check_output("mb_board", bus.mb_board, board_m);
      check_output("game_over", 80'(game_over), 80'(fm < 0));
      check_output("key_ready", 80'(bus.key_ready), 80'(fm >= 0));
      if (fm >= 0) check_output("mb_dir_probe", 80'(bus.mb_dir), 80'(fm));
      check_output("win", 80'(win), 80'(win_m));
   endtask

   task automatic apply_stimulus_load(input logic [79:0] b);
      load_board = b;
      load       = 1'b1;
      @(negedge clk);
      load       = 1'b0;
      board_m    = b;
      win_m      = win_m | any_win(b);
      check_output("load_board", board, b);
      check_output("load_win", 80'(win), 80'(win_m));
      expect_settled();
   endtask

   task automatic apply_stimulus_start(input bit with_load);
      logic [15:0] snap = lfsr_m;
      start = 1'b1;
      if (with_load) begin
         load       = 1'b1;
         load_board = 80'd11;
      end
      @(negedge clk);
      start = 1'b0;
      load  = 1'b0;
      check_output("start_clear", board, 80'd0);
      check_output("start_win", 80'(win), 80'd0);
      check_output("start_over", 80'(game_over), 80'd0);
      check_output("start_ready", 80'(bus.key_ready), 80'd0);
      load_board = {$urandom, $urandom, 16'(0)};
      load       = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      board_m = predict_spawn(80'd0, snap, 2);
      win_m   = 1'b0;
      expect_settled();
      check_output("start_latency", 80'(last_cyc <= 33), 80'd1);
      check_output("start_tiles", 80'(count_nz(board)), 80'd2);
   endtask

   // Key is held through MOVE and COMMIT (with a wandering direction) to prove it is taken once.
   task automatic apply_stimulus_key(input logic [1:0] dir);
      logic [15:0] snap = lfsr_m;
      logic [79:0] after = merge(board_m, dir);
      bit          movable = (after != board_m);
      bus.key_valid = 1'b1;
      bus.key_dir   = dir;
      @(negedge clk);
      bus.key_dir = 2'($urandom_range(0, 3));
      check_output("ready_move", 80'(bus.key_ready), 80'd0);
      @(negedge clk);
      check_output("ready_commit", 80'(bus.key_ready), 80'd0);
      @(negedge clk);
      bus.key_valid = 1'b0;
      check_output("commit_board", board, after);
      check_output("ready_back", 80'(bus.key_ready), 80'(!movable));
      if (movable) begin
         win_m   = win_m | any_win(after);
         board_m = predict_spawn(after, adv(snap, 2), 1);
         expect_settled();
      end else begin
         check_output("stuck_dir", 80'(bus.mb_dir), 80'(dir));
         @(negedge clk);
         check_output("no_second_move", board, board_m);
         check_output("stuck_ready", 80'(bus.key_ready), 80'd1);
      end
   endtask

   initial begin
      logic [79:0] chk_board;
      rst_n         = 1'b0;
      start         = 1'b0;
      load          = 1'b0;
      load_board    = '0;
      bus.key_valid = 1'b0;
      bus.key_dir   = 2'd0;
      board_m       = '0;
      win_m         = 1'b0;
      #12;
      check_output("rst_board", board, 80'd0);
      check_output("rst_ready", 80'(bus.key_ready), 80'd0);
      check_output("rst_over", 80'(game_over), 80'd0);
      check_output("rst_win", 80'(win), 80'd0);
      check_output("rst_dir", 80'(bus.mb_dir), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Winning tile, then reset in the middle of the spawn that follows a move.
      apply_stimulus_load(80'd11);
      bus.key_valid = 1'b1;
      bus.key_dir   = 2'd1;
      repeat (3) @(negedge clk);
      bus.key_valid = 1'b0;
      check_output("pre_rst_board", board, merge(80'd11, 2'd1));
      check_output("pre_rst_ready", 80'(bus.key_ready), 80'd0);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_board", board, 80'd0);
      check_output("async_ready", 80'(bus.key_ready), 80'd0);
      check_output("async_over", 80'(game_over), 80'd0);
      check_output("async_win", 80'(win), 80'd0);
      check_output("async_dir", 80'(bus.mb_dir), 80'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      board_m = '0;
      win_m   = 1'b0;
      @(negedge clk);

      apply_stimulus_start(1'b0);
      for (int n = 0; n < 30; n++) begin
         if (game_over) apply_stimulus_start(1'b0);
         else           apply_stimulus_key(2'($urandom_range(0, 3)));
      end

      // Pair of 2-tiles in row 0 slid toward cell 0.
      apply_stimulus_load({70'd0, 5'd1, 5'd1});
      apply_stimulus_key(2'd0);
      check_output("pair_tiles", 80'(count_nz(board)), 80'd2);

      for (int i = 0; i < 16; i++)
         chk_board[5*i +: 5] = (((i / 4) + (i % 4)) % 2 == 1) ? 5'd2 : 5'd1;
      apply_stimulus_load(chk_board);
      check_output("over_latency", 80'(last_cyc <= 8), 80'd1);
      bus.key_valid = 1'b1;
      repeat (3) begin
         bus.key_dir = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      bus.key_valid = 1'b0;
      @(negedge clk);
      check_output("over_board", board, chk_board);
      check_output("over_flag", 80'(game_over), 80'd1);
      check_output("over_ready", 80'(bus.key_ready), 80'd0);

      apply_stimulus_load(80'd11);
      apply_stimulus_start(1'b1);
      for (int n = 0; n < 8; n++) begin
         if (game_over) apply_stimulus_start(1'b0);
         else           apply_stimulus_key(2'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
